// File: rtl/lsu.sv
// rtl/lsu.sv - RV32E load/store stage: one data-memory transaction per op, load formatting, rd handoff
module lsu #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_exu_valid,
    output logic        o_lsu_ready,
    input  logic        i_exu_ld,
    input  logic        i_exu_st,
    input  logic [2:0]  i_exu_funct3,
    input  logic [31:0] i_exu_addr,
    input  logic [31:0] i_exu_st_data,
    input  logic [3:0]  i_exu_rd,
    output logic        o_lsu_valid,
    input  logic        i_wbu_ready,
    output logic [31:0] o_lsu_rd_data,
    output logic [3:0]  o_lsu_rd,
    output logic        o_lsu_wen,
    output logic        o_lsu_err,
    output logic [1:0]  o_lsu_err_cause,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wmask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [2:0]    r_funct3;
    logic          w_accept;
    logic          w_is_mem;
    logic          w_illegal;
    logic          w_misalign;
    logic          w_timeout;
    logic [31:0]   w_shift;
    logic [31:0]   w_ld_data;

    assign w_accept  = i_exu_valid && (r_state == S_IDLE);
    assign w_is_mem  = i_exu_ld || i_exu_st;
    assign w_illegal = (i_exu_ld && i_exu_st)
                    || (i_exu_ld && (i_exu_funct3 == 3'b011 || i_exu_funct3 == 3'b110 || i_exu_funct3 == 3'b111))
                    || (i_exu_st && (i_exu_funct3 > 3'b010));
    assign w_misalign = w_is_mem && (((i_exu_funct3[1:0] == 2'b01) && i_exu_addr[0])
                                  || ((i_exu_funct3[1:0] == 2'b10) && (i_exu_addr[1:0] != 2'b00)));
    // Last allowed REQ/WAIT cycle: the counter was cleared on accept and counts cycles already spent.
    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYC - 1));
    assign w_shift   = i_mem_rdata >> {r_addr[1:0], 3'b000};

    // Load data formatting: byte/half extracted from the shifted word, sign or zero extended.
    always_comb begin
        w_ld_data = w_shift;
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ld_data = {24'h0, w_shift[7:0]};
            3'b101:  w_ld_data = {16'h0, w_shift[15:0]};
            default: w_ld_data = w_shift;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; a grant/rvalid arriving on the last allowed cycle still completes the op.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (w_illegal || w_misalign || !w_is_mem) ? S_DONE : S_REQ;
            S_REQ:  if (i_mem_gnt) w_next = o_mem_we ? S_DONE : S_WAIT;
                    else if (w_timeout) w_next = S_DONE;
            S_WAIT: if (i_mem_rvalid || w_timeout) w_next = S_DONE;
            S_DONE: if (i_wbu_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes.
    always_comb begin
        o_lsu_ready = (r_state == S_IDLE);
        o_mem_req   = (r_state == S_REQ);
        o_lsu_valid = (r_state == S_DONE);
    end

    // Datapath: latch the op on accept, build the bus payload, and record the result.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt           <= '0;
            r_addr          <= '0;
            r_funct3        <= '0;
            o_lsu_rd_data   <= '0;
            o_lsu_rd        <= '0;
            o_lsu_wen       <= 1'b0;
            o_lsu_err       <= 1'b0;
            o_lsu_err_cause <= 2'b00;
            o_mem_we        <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_wdata     <= '0;
            o_mem_wmask     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt    <= '0;
                    r_addr   <= i_exu_addr;
                    r_funct3 <= i_exu_funct3;
                    o_lsu_rd <= i_exu_rd;
                    o_lsu_rd_data <= i_exu_addr;
                    if (w_illegal || w_misalign) begin
                        o_lsu_wen       <= 1'b0;
                        o_lsu_err       <= 1'b1;
                        o_lsu_err_cause <= w_illegal ? 2'b10 : 2'b01;
                    end else if (!w_is_mem) begin
                        o_lsu_wen       <= (i_exu_rd != 4'd0);
                        o_lsu_err       <= 1'b0;
                        o_lsu_err_cause <= 2'b00;
                    end else begin
                        o_lsu_wen       <= 1'b0;
                        o_lsu_err       <= 1'b0;
                        o_lsu_err_cause <= 2'b00;
                        o_mem_we        <= i_exu_st;
                        o_mem_addr      <= {i_exu_addr[31:2], 2'b00};
                        if (!i_exu_st) begin
                            o_mem_wdata <= '0;
                            o_mem_wmask <= '0;
                        end else begin
                            case (i_exu_funct3[1:0])
                                2'b00: begin
                                    o_mem_wdata <= {4{i_exu_st_data[7:0]}};
                                    o_mem_wmask <= 4'b0001 << i_exu_addr[1:0];
                                end
                                2'b01: begin
                                    o_mem_wdata <= {2{i_exu_st_data[15:0]}};
                                    o_mem_wmask <= 4'b0011 << i_exu_addr[1:0];
                                end
                                default: begin
                                    o_mem_wdata <= i_exu_st_data;
                                    o_mem_wmask <= 4'b1111;
                                end
                            endcase
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_mem_gnt) begin
                        if (o_mem_we) o_lsu_rd_data <= '0;
                    end else if (w_timeout) begin
                        o_lsu_err       <= 1'b1;
                        o_lsu_err_cause <= 2'b11;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_mem_rvalid) begin
                        o_lsu_rd_data <= w_ld_data;
                        o_lsu_wen     <= (o_lsu_rd != 4'd0);
                    end else if (w_timeout) begin
                        o_lsu_err       <= 1'b1;
                        o_lsu_err_cause <= 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed scoreboard bench for the load/store stage
module tb_lsu;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_exu_valid = 1'b0;
    logic        o_lsu_ready;
    logic        i_exu_ld = 1'b0;
    logic        i_exu_st = 1'b0;
    logic [2:0]  i_exu_funct3 = '0;
    logic [31:0] i_exu_addr = '0;
    logic [31:0] i_exu_st_data = '0;
    logic [3:0]  i_exu_rd = '0;
    logic        o_lsu_valid;
    logic        i_wbu_ready = 1'b1;
    logic [31:0] o_lsu_rd_data;
    logic [3:0]  o_lsu_rd;
    logic        o_lsu_wen;
    logic        o_lsu_err;
    logic [1:0]  o_lsu_err_cause;
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd;
        logic        wen;
        logic        err;
        logic [1:0]  cause;
        bit          chk_data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    int          gnt_delay = 0;
    logic [31:0] rd_word = '0;
    bit          rd_pend = 0;
    bit          hold_rv = 0;
    bit          stray_rv = 0;
    int          req_cnt = 0;

    always #5 i_clk = ~i_clk;

    lsu #(.TIMEOUT_CYC(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_exu_valid(i_exu_valid), .o_lsu_ready(o_lsu_ready),
        .i_exu_ld(i_exu_ld), .i_exu_st(i_exu_st), .i_exu_funct3(i_exu_funct3),
        .i_exu_addr(i_exu_addr), .i_exu_st_data(i_exu_st_data), .i_exu_rd(i_exu_rd),
        .o_lsu_valid(o_lsu_valid), .i_wbu_ready(i_wbu_ready),
        .o_lsu_rd_data(o_lsu_rd_data), .o_lsu_rd(o_lsu_rd), .o_lsu_wen(o_lsu_wen),
        .o_lsu_err(o_lsu_err), .o_lsu_err_cause(o_lsu_err_cause),
        .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    // Memory responder: grant after gnt_delay request cycles (never if negative), rvalid the cycle after a load grant.
    initial begin
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            i_mem_rvalid = (rd_pend && !hold_rv) || stray_rv;
            i_mem_rdata  = rd_pend ? rd_word : 32'h0;
            if (!hold_rv) rd_pend = 0;
            if (o_mem_req && gnt_delay >= 0 && req_cnt >= gnt_delay) begin
                i_mem_gnt = 1'b1; rd_pend = !o_mem_we; req_cnt = 0;
            end else begin
                i_mem_gnt = 1'b0; req_cnt = o_mem_req ? req_cnt + 1 : 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [3:0] rd, input logic wen,
                                input logic err, input logic [1:0] cause, input bit cd);
        exp_t e;
        e.data = d; e.rd = rd; e.wen = wen; e.err = err; e.cause = cause; e.chk_data = cd;
        return e;
    endfunction

    // Drive one op at a negedge in IDLE, watch the bus each cycle, then score the result.
    task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [3:0] rd,
                          input exp_t e, input int lat, input int nreq,
                          input logic we, input logic [31:0] maddr, input logic [31:0] wdata,
                          input logic [3:0] wmask);
        int   n;
        int   reqs;
        exp_t g;
        chk({tag, "_ready"}, o_lsu_ready, 1);
        i_exu_valid = 1; i_exu_ld = ld; i_exu_st = st; i_exu_funct3 = f3;
        i_exu_addr = addr; i_exu_st_data = sd; i_exu_rd = rd;
        exp_q.push_back(e);
        @(posedge i_clk); #1;
        i_exu_valid = 0; i_exu_ld = 0; i_exu_st = 0;
        @(negedge i_clk);
        n = 1; reqs = 0;
        while (!o_lsu_valid && n < 40) begin
            if (o_mem_req) begin
                reqs++;
                chk({tag, "_we"}, o_mem_we, we);
                chk({tag, "_maddr"}, o_mem_addr, maddr);
                chk({tag, "_wdata"}, o_mem_wdata, wdata);
                chk({tag, "_wmask"}, o_mem_wmask, wmask);
            end
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_reqcycles"}, reqs, nreq);
        chk({tag, "_req_in_done"}, o_mem_req, 0);
        if (exp_q.size() > 0) begin
            g = exp_q.pop_front();
            if (g.chk_data) chk({tag, "_rd_data"}, o_lsu_rd_data, g.data);
            chk({tag, "_rd"}, o_lsu_rd, g.rd);
            chk({tag, "_wen"}, o_lsu_wen, g.wen);
            chk({tag, "_err"}, o_lsu_err, g.err);
            chk({tag, "_cause"}, o_lsu_err_cause, g.cause);
        end
        if (i_wbu_ready) @(negedge i_clk);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        chk("rst_ready", o_lsu_ready, 1);
        chk("rst_valid", o_lsu_valid, 0);
        chk("rst_req", o_mem_req, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_wen", o_lsu_wen, 0);
        chk("rst_err", o_lsu_err, 0);
        chk("rst_cause", o_lsu_err_cause, 0);
        chk("rst_rd_data", o_lsu_rd_data, 0);
        chk("rst_maddr", o_mem_addr, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        chk("rst_wmask", o_mem_wmask, 0);
        i_rst = 1;
        @(negedge i_clk);

        run_op("byp", 0, 0, 3'b000, 32'h1234, 0, 4'd5, mk(32'h1234, 5, 1, 0, 0, 1), 1, 0, 0, 0, 0, 0);
        run_op("byp_rd0", 0, 0, 3'b000, 32'h1234, 0, 4'd0, mk(32'h1234, 0, 0, 0, 0, 1), 1, 0, 0, 0, 0, 0);

        gnt_delay = 0; rd_word = 32'h80FF_FF7F;
        run_op("lb", 1, 0, 3'b000, 32'h103, 0, 4'd7, mk(32'hFFFF_FF80, 7, 1, 0, 0, 1), 3, 1, 0, 32'h100, 0, 0);
        run_op("lbu", 1, 0, 3'b100, 32'h103, 0, 4'd7, mk(32'h0000_0080, 7, 1, 0, 0, 1), 3, 1, 0, 32'h100, 0, 0);
        run_op("lh", 1, 0, 3'b001, 32'h102, 0, 4'd1, mk(32'hFFFF_80FF, 1, 1, 0, 0, 1), 3, 1, 0, 32'h100, 0, 0);
        run_op("lhu", 1, 0, 3'b101, 32'h102, 0, 4'd1, mk(32'h0000_80FF, 1, 1, 0, 0, 1), 3, 1, 0, 32'h100, 0, 0);
        rd_word = 32'hDEAD_BEEF;
        run_op("lw_rd0", 1, 0, 3'b010, 32'h300, 0, 4'd0, mk(32'hDEAD_BEEF, 0, 0, 0, 0, 1), 3, 1, 0, 32'h300, 0, 0);

        gnt_delay = 3;
        run_op("sh", 0, 1, 3'b001, 32'h202, 32'hABCD_1234, 4'd3, mk(32'h0, 3, 0, 0, 0, 1), 5, 4, 1, 32'h200, 32'h1234_1234, 4'b1100);
        gnt_delay = 0;
        run_op("sb", 0, 1, 3'b000, 32'h101, 32'h0000_0055, 4'd3, mk(32'h0, 3, 0, 0, 0, 1), 2, 1, 1, 32'h100, 32'h5555_5555, 4'b0010);
        run_op("sw", 0, 1, 3'b010, 32'h40, 32'hCAFE_F00D, 4'd4, mk(32'h0, 4, 0, 0, 0, 1), 2, 1, 1, 32'h40, 32'hCAFE_F00D, 4'b1111);

        run_op("lw_mis", 1, 0, 3'b010, 32'h101, 0, 4'd2, mk(32'h101, 2, 0, 1, 2'b01, 1), 1, 0, 0, 0, 0, 0);
        run_op("lh_mis", 1, 0, 3'b001, 32'h201, 0, 4'd2, mk(32'h201, 2, 0, 1, 2'b01, 1), 1, 0, 0, 0, 0, 0);
        run_op("ldst", 1, 1, 3'b010, 32'h100, 0, 4'd2, mk(32'h100, 2, 0, 1, 2'b10, 1), 1, 0, 0, 0, 0, 0);
        run_op("ld_f3", 1, 0, 3'b011, 32'h100, 0, 4'd2, mk(32'h100, 2, 0, 1, 2'b10, 1), 1, 0, 0, 0, 0, 0);
        run_op("st_f3", 0, 1, 3'b011, 32'h104, 0, 4'd2, mk(32'h104, 2, 0, 1, 2'b10, 1), 1, 0, 0, 0, 0, 0);

        i_wbu_ready = 0;
        run_op("bp", 0, 0, 3'b000, 32'h5A5A, 0, 4'd9, mk(32'h5A5A, 9, 1, 0, 0, 1), 1, 0, 0, 0, 0, 0);
        repeat (3) @(negedge i_clk);
        chk("bp_valid_held", o_lsu_valid, 1);
        chk("bp_data_held", o_lsu_rd_data, 32'h5A5A);
        chk("bp_ready_low", o_lsu_ready, 0);
        i_wbu_ready = 1;
        @(negedge i_clk);
        chk("bp_released", o_lsu_valid, 0);
        chk("bp_idle", o_lsu_ready, 1);

        gnt_delay = -1;
        run_op("tmo", 1, 0, 3'b010, 32'h80, 0, 4'd6, mk(32'h0, 6, 0, 1, 2'b11, 0), 9, 8, 0, 32'h80, 0, 0);
        stray_rv = 1;
        repeat (2) begin
            @(negedge i_clk);
            chk("late_rv_valid", o_lsu_valid, 0);
            chk("late_rv_ready", o_lsu_ready, 1);
        end
        stray_rv = 0;
        @(negedge i_clk);

        gnt_delay = 0; hold_rv = 1; rd_word = 32'h1122_3344;
        i_exu_valid = 1; i_exu_ld = 1; i_exu_funct3 = 3'b010; i_exu_addr = 32'h10; i_exu_rd = 4'd2;
        @(posedge i_clk); #1;
        i_exu_valid = 0; i_exu_ld = 0;
        @(negedge i_clk);
        chk("rw_req", o_mem_req, 1);
        @(negedge i_clk);
        chk("rw_in_wait_req", o_mem_req, 0);
        chk("rw_in_wait_ready", o_lsu_ready, 0);
        #1 i_rst = 0;
        #1;
        chk("rw_req_now", o_mem_req, 0);
        chk("rw_valid_now", o_lsu_valid, 0);
        chk("rw_ready_now", o_lsu_ready, 1);
        chk("rw_maddr_now", o_mem_addr, 0);
        @(negedge i_clk);
        i_rst = 1; hold_rv = 0;
        repeat (2) @(negedge i_clk);
        chk("rw_after_valid", o_lsu_valid, 0);
        run_op("post_rst", 1, 0, 3'b010, 32'h10, 0, 4'd2, mk(32'h1122_3344, 2, 1, 0, 0, 1), 3, 1, 0, 32'h10, 0, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
